// File: rtl/axil_ctrl_regs_pkg.sv
// Shared definitions for the AXI-Lite control register block: register map,
// response codes, FSM state types and the address decoder.
package axil_ctrl_pkg;

   localparam logic [11:0] OFF_CTRL     = 12'h000;
   localparam logic [11:0] OFF_SCRATCH  = 12'h004;
   localparam logic [11:0] OFF_STATUS   = 12'h008;
   localparam logic [11:0] OFF_DROP_CNT = 12'h00C;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int CTRL_ENABLE_BIT   = 0;
   localparam int CTRL_CLR_DROP_BIT = 31;

   typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

   typedef enum logic [2:0] {
      REG_CTRL,
      REG_SCRATCH,
      REG_STATUS,
      REG_DROP_CNT,
      REG_NONE
   } reg_sel_t;

   typedef struct packed {
      logic [1:0] resp;
      reg_sel_t   sel;
   } decode_t;

   // Addresses below base wrap to a huge offset, so one compare covers both window edges.
   function automatic decode_t decode_addr(input logic [31:0] addr, input logic [31:0] base);
      logic [31:0] off;
      decode_t     d;
      off    = addr - base;
      d.sel  = REG_NONE;
      d.resp = RESP_SLVERR;
      if (off > 32'h0000_0FFF) begin
         d.resp = RESP_DECERR;
      end else if (addr[1:0] == 2'b00) begin
         d.resp = RESP_OKAY;
         case (off[11:0])
            OFF_CTRL:     d.sel = REG_CTRL;
            OFF_SCRATCH:  d.sel = REG_SCRATCH;
            OFF_STATUS:   d.sel = REG_STATUS;
            OFF_DROP_CNT: d.sel = REG_DROP_CNT;
            default:      d.resp = RESP_SLVERR;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/axil_ctrl_regs_if.sv
// AXI-Lite slave bus bundle. A beat transfers on a rising edge where valid and
// ready are both 1; valid never waits on ready, and payload holds while valid is up.
interface axil_ctrl_regs_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic        bvalid;
   logic [1:0]  bresp;
   logic        bready;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rready;

   modport master (
      output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axil_ctrl_regs_sat_counter32.sv
// 32-bit up counter that sticks at all-ones; clear beats increment.
module sat_counter32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        clr,
   output logic [31:0] count
);

   logic [31:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_q <= '0;
      end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/axil_ctrl_regs.sv
// AXI-Lite control/status register block: CTRL, SCRATCH, STATUS and a
// saturating DROP_CNT, with independent write and read channel FSMs.
module axil_ctrl_regs
   import axil_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
   input  logic        axil_aclk,
   input  logic        axil_rst,
   axil_ctrl_regs_if.slave s_axil,
   output logic        ctrl_enable,
   input  logic [31:0] status_in,
   input  logic        drop_pulse,
   output wr_state_t   dbg_wr_state_o,
   output rd_state_t   dbg_rd_state_o
);

   wr_state_t   wr_state_q;
   logic        aw_lat_q;
   logic        w_lat_q;
   logic [31:0] awaddr_q;
   logic [31:0] wdata_q;
   logic        bvalid_q;
   logic [1:0]  bresp_q;
   logic        ctrl_en_q;
   logic [31:0] scratch_q;

   rd_state_t   rd_state_q;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;

   decode_t     wr_dec;
   logic [1:0]  wr_resp;
   logic        commit;
   logic        commit_ok;
   logic        drop_clr;
   logic        aw_hs;
   logic        w_hs;

   decode_t     rd_dec;
   logic [31:0] ctrl_word;
   logic [31:0] rdata_d;
   logic [1:0]  rresp_d;
   logic        ar_hs;
   logic [31:0] drop_cnt;

   // Ready lines drop while reset is held so nothing is accepted in that window.
   assign s_axil.awready = !axil_rst && (wr_state_q == WR_IDLE) && !aw_lat_q;
   assign s_axil.wready  = !axil_rst && (wr_state_q == WR_IDLE) && !w_lat_q;
   assign s_axil.arready = !axil_rst && (rd_state_q == RD_IDLE);
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;
   assign s_axil.rvalid  = rvalid_q;
   assign s_axil.rdata   = rdata_q;
   assign s_axil.rresp   = rresp_q;

   assign aw_hs = s_axil.awvalid && s_axil.awready;
   assign w_hs  = s_axil.wvalid && s_axil.wready;
   assign ar_hs = s_axil.arvalid && s_axil.arready;

   assign ctrl_enable    = ctrl_en_q;
   assign dbg_wr_state_o = wr_state_q;
   assign dbg_rd_state_o = rd_state_q;

   always_comb begin
      wr_dec  = decode_addr(awaddr_q, BASE_ADDR);
      wr_resp = wr_dec.resp;
      if ((wr_dec.sel == REG_STATUS) || (wr_dec.sel == REG_DROP_CNT)) begin
         wr_resp = RESP_SLVERR;
      end
      commit    = (wr_state_q == WR_IDLE) && aw_lat_q && w_lat_q;
      commit_ok = commit && (wr_resp == RESP_OKAY);
      drop_clr  = commit_ok && (wr_dec.sel == REG_CTRL) && wdata_q[CTRL_CLR_DROP_BIT];
   end

   always_comb begin
      rd_dec    = decode_addr(s_axil.araddr, BASE_ADDR);
      rresp_d   = rd_dec.resp;
      ctrl_word = '0;
      ctrl_word[CTRL_ENABLE_BIT] = ctrl_en_q;
      case (rd_dec.sel)
         REG_CTRL:     rdata_d = ctrl_word;
         REG_SCRATCH:  rdata_d = scratch_q;
         REG_STATUS:   rdata_d = status_in;
         REG_DROP_CNT: rdata_d = drop_cnt;
         default:      rdata_d = '0;
      endcase
   end

   always_ff @(posedge axil_aclk) begin
      if (axil_rst) begin
         wr_state_q <= WR_IDLE;
         aw_lat_q   <= 1'b0;
         w_lat_q    <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         ctrl_en_q  <= 1'b0;
         scratch_q  <= '0;
      end else begin
         case (wr_state_q)
            WR_IDLE: begin
               if (commit) begin
                  aw_lat_q   <= 1'b0;
                  w_lat_q    <= 1'b0;
                  bvalid_q   <= 1'b1;
                  bresp_q    <= wr_resp;
                  wr_state_q <= WR_RESP;
                  if (commit_ok && (wr_dec.sel == REG_CTRL)) begin
                     ctrl_en_q <= wdata_q[CTRL_ENABLE_BIT];
                  end
                  if (commit_ok && (wr_dec.sel == REG_SCRATCH)) begin
                     scratch_q <= wdata_q;
                  end
               end else begin
                  if (aw_hs) begin
                     aw_lat_q <= 1'b1;
                     awaddr_q <= s_axil.awaddr;
                  end
                  if (w_hs) begin
                     w_lat_q <= 1'b1;
                     wdata_q <= s_axil.wdata;
                  end
               end
            end
            WR_RESP: begin
               if (s_axil.bready) begin
                  bvalid_q   <= 1'b0;
                  wr_state_q <= WR_IDLE;
               end
            end
            default: wr_state_q <= WR_IDLE;
         endcase
      end
   end

   // Read data is captured at the acceptance edge, so a same-edge write commit is not visible.
   always_ff @(posedge axil_aclk) begin
      if (axil_rst) begin
         rd_state_q <= RD_IDLE;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         case (rd_state_q)
            RD_IDLE: begin
               if (ar_hs) begin
                  rvalid_q   <= 1'b1;
                  rdata_q    <= rdata_d;
                  rresp_q    <= rresp_d;
                  rd_state_q <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (s_axil.rready) begin
                  rvalid_q   <= 1'b0;
                  rd_state_q <= RD_IDLE;
               end
            end
            default: rd_state_q <= RD_IDLE;
         endcase
      end
   end

   sat_counter32 u_drop_cnt (
      .clk   (axil_aclk),
      .rst   (axil_rst),
      .inc   (drop_pulse),
      .clr   (drop_clr),
      .count (drop_cnt)
   );

endmodule
